// File: rtl/riscv_checker_pkg.sv
// Shared types for the RISC-V result checker: run states, fail codes
// and the table entry layout.
package riscv_checker_pkg;

    localparam int ENTRY_DW = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PASSED = 2'd2,
        FAILED = 2'd3
    } state_t;

    localparam logic [1:0] FAIL_NONE     = 2'b00;
    localparam logic [1:0] FAIL_MISMATCH = 2'b01;
    localparam logic [1:0] FAIL_MISSED   = 2'b10;
    localparam logic [1:0] FAIL_TIMEOUT  = 2'b11;

    typedef struct packed {
        logic [31:0]         num_inst;
        logic [ENTRY_DW-1:0] ans;
        logic [ENTRY_DW-1:0] mask;
    } entry_t;

endpackage

// File: rtl/riscv_checker_table.sv
// Expected-result table: register array with one synchronous write
// port and one asynchronous read port; contents survive reset.
module riscv_checker_table
    import riscv_checker_pkg::*;
#(
    parameter int NUM_TEST = 32,
    parameter int IDX_W    = 5
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] wr_idx,
    input  entry_t           wr_entry,
    input  logic [IDX_W-1:0] rd_idx,
    output entry_t           rd_entry
);

    entry_t mem [NUM_TEST];

    // Table write, no reset so loaded entries outlive a run abort.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_idx] <= wr_entry;
        end
    end

    assign rd_entry = mem[rd_idx];

endmodule

// File: rtl/riscv_result_checker.sv
// Table-driven pass/fail scoreboard that runs beside RISCV_TOP.
// Macro RISCV_CHECKER_TIMEOUT_EN adds a RUN cycle limit (fail code 11).
module riscv_result_checker
    import riscv_checker_pkg::*;
#(
    parameter int NUM_TEST    = 32,
    parameter int DWIDTH      = 32,
    parameter int IDX_W       = 5,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              CFG_WE,
    input  logic [IDX_W-1:0]  CFG_IDX,
    input  logic [31:0]       CFG_NUM_INST,
    input  logic [DWIDTH-1:0] CFG_ANS,
    input  logic [DWIDTH-1:0] CFG_MASK,
    input  logic [IDX_W:0]    CFG_COUNT,
    input  logic              START,
    input  logic [31:0]       NUM_INST,
    input  logic [DWIDTH-1:0] OUTPUT_PORT,
    input  logic              HALT,
    output logic              BUSY,
    output logic              DONE,
    output logic              PASS,
    output logic [1:0]        FAIL_CODE,
    output logic [IDX_W-1:0]  FAIL_IDX,
    output logic [DWIDTH-1:0] FAIL_VALUE,
    output logic [IDX_W:0]    PASS_CNT,
    output logic [31:0]       CYCLE
);

    localparam logic [IDX_W:0] MAX_CNT = (IDX_W+1)'(NUM_TEST);
    localparam logic [IDX_W:0] ONE     = (IDX_W+1)'(1);

    state_t              state, state_nxt;
    logic [IDX_W:0]      ptr, ptr_nxt;
    logic [IDX_W:0]      count_r, count_nxt;
    logic [31:0]         cycle, cycle_nxt;
    logic [1:0]          code, code_nxt;
    logic [IDX_W-1:0]    fidx, fidx_nxt;
    logic [DWIDTH-1:0]   fval, fval_nxt;
    logic                check_fail;
    logic                timeout_hit;
    logic [IDX_W:0]      count_in;
    entry_t              wr_entry;
    entry_t              rd_entry;
    logic [DWIDTH-1:0]   e_ans;
    logic [DWIDTH-1:0]   e_mask;

    assign wr_entry.num_inst = CFG_NUM_INST;
    assign wr_entry.ans      = ENTRY_DW'(CFG_ANS);
    assign wr_entry.mask     = ENTRY_DW'(CFG_MASK);

    riscv_checker_table #(
        .NUM_TEST (NUM_TEST),
        .IDX_W    (IDX_W)
    ) u_table (
        .clk      (CLK),
        .we       (CFG_WE && (state == IDLE)),
        .wr_idx   (CFG_IDX),
        .wr_entry (wr_entry),
        .rd_idx   (ptr[IDX_W-1:0]),
        .rd_entry (rd_entry)
    );

    assign e_ans    = DWIDTH'(rd_entry.ans);
    assign e_mask   = DWIDTH'(rd_entry.mask);
    assign count_in = (CFG_COUNT > MAX_CNT) ? MAX_CNT : CFG_COUNT;

`ifdef RISCV_CHECKER_TIMEOUT_EN
    assign timeout_hit = (cycle == 32'(TIMEOUT_CYC - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // Next-state: one entry check per RUN cycle, then HALT, then timeout.
    always_comb begin
        state_nxt  = state;
        ptr_nxt    = ptr;
        count_nxt  = count_r;
        cycle_nxt  = cycle;
        code_nxt   = code;
        fidx_nxt   = fidx;
        fval_nxt   = fval;
        check_fail = 1'b0;
        unique case (state)
            RUN: begin
                cycle_nxt = cycle + 32'd1;
                if (ptr < count_r) begin
                    if (NUM_INST == rd_entry.num_inst) begin
                        if (((OUTPUT_PORT ^ e_ans) & e_mask) == '0) begin
                            ptr_nxt = ptr + ONE;
                        end else begin
                            check_fail = 1'b1;
                            code_nxt   = FAIL_MISMATCH;
                        end
                    end else if (NUM_INST > rd_entry.num_inst) begin
                        check_fail = 1'b1;
                        code_nxt   = FAIL_MISSED;
                    end
                end
                if (check_fail) begin
                    state_nxt = FAILED;
                    fidx_nxt  = ptr[IDX_W-1:0];
                    fval_nxt  = OUTPUT_PORT;
                end else if (HALT) begin
                    if (ptr_nxt == count_r) begin
                        state_nxt = PASSED;
                    end else begin
                        state_nxt = FAILED;
                        code_nxt  = FAIL_MISSED;
                        fidx_nxt  = ptr_nxt[IDX_W-1:0];
                        fval_nxt  = OUTPUT_PORT;
                    end
                end else if (timeout_hit) begin
                    state_nxt = FAILED;
                    code_nxt  = FAIL_TIMEOUT;
                    fidx_nxt  = ptr[IDX_W-1:0];
                    fval_nxt  = OUTPUT_PORT;
                end
            end
            IDLE, PASSED, FAILED: begin
                if (START) begin
                    state_nxt = RUN;
                    ptr_nxt   = '0;
                    count_nxt = count_in;
                    cycle_nxt = '0;
                    code_nxt  = FAIL_NONE;
                    fidx_nxt  = '0;
                    fval_nxt  = '0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State and result registers, synchronous active-high reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            ptr     <= '0;
            count_r <= '0;
            cycle   <= '0;
            code    <= FAIL_NONE;
            fidx    <= '0;
            fval    <= '0;
        end else begin
            state   <= state_nxt;
            ptr     <= ptr_nxt;
            count_r <= count_nxt;
            cycle   <= cycle_nxt;
            code    <= code_nxt;
            fidx    <= fidx_nxt;
            fval    <= fval_nxt;
        end
    end

    assign BUSY       = (state == RUN);
    assign DONE       = (state == PASSED) || (state == FAILED);
    assign PASS       = (state == PASSED);
    assign FAIL_CODE  = code;
    assign FAIL_IDX   = fidx;
    assign FAIL_VALUE = fval;
    assign PASS_CNT   = ptr;
    assign CYCLE      = cycle;

endmodule

// File: tb/tb_riscv_result_checker.sv
// Bench for riscv_result_checker: directed scenarios plus random runs,
// every cycle compared against a behavioural scoreboard model.
module tb_riscv_result_checker;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_we = 1'b0;
    logic [4:0]  cfg_idx = '0;
    logic [31:0] cfg_ni = '0;
    logic [31:0] cfg_ans = '0;
    logic [31:0] cfg_mask = '0;
    logic [5:0]  cfg_count = '0;
    logic        start = 1'b0;
    logic [31:0] num_inst = '0;
    logic [31:0] out_port = '0;
    logic        halt = 1'b0;

    logic        busy, done, pass;
    logic [1:0]  fcode;
    logic [4:0]  fidx;
    logic [31:0] fval;
    logic [5:0]  pcnt;
    logic [31:0] cyc;

    int n_tests = 0;
    int n_fail  = 0;
    bit armed   = 0;

    riscv_result_checker #(
        .NUM_TEST    (32),
        .DWIDTH      (32),
        .IDX_W       (5),
        .TIMEOUT_CYC (TO)
    ) dut (
        .CLK          (clk),
        .RST          (rst),
        .CFG_WE       (cfg_we),
        .CFG_IDX      (cfg_idx),
        .CFG_NUM_INST (cfg_ni),
        .CFG_ANS      (cfg_ans),
        .CFG_MASK     (cfg_mask),
        .CFG_COUNT    (cfg_count),
        .START        (start),
        .NUM_INST     (num_inst),
        .OUTPUT_PORT  (out_port),
        .HALT         (halt),
        .BUSY         (busy),
        .DONE         (done),
        .PASS         (pass),
        .FAIL_CODE    (fcode),
        .FAIL_IDX     (fidx),
        .FAIL_VALUE   (fval),
        .PASS_CNT     (pcnt),
        .CYCLE        (cyc)
    );

    always #5 clk = ~clk;

    // Behavioural model: what a checker following the rules must report.
    localparam int M_IDLE = 0, M_RUN = 1, M_PASS = 2, M_FAIL = 3;
    int          m_st = M_IDLE;
    int          m_passed = 0;
    int          m_cnt = 0;
    int unsigned m_cyc = 0;
    int          m_code = 0;
    int          m_idx = 0;
    logic [31:0] m_val = '0;
    logic [31:0] t_ni [32];
    logic [31:0] t_ans [32];
    logic [31:0] t_mask [32];

    task automatic model_fail(input int c, input int i);
        m_st   = M_FAIL;
        m_code = c;
        m_idx  = i;
        m_val  = out_port;
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_st = M_IDLE; m_passed = 0; m_cnt = 0; m_cyc = 0;
            m_code = 0; m_idx = 0; m_val = '0;
        end else if (m_st == M_RUN) begin
            bit bad;
            bad = 0;
            m_cyc = m_cyc + 1;
            if (m_passed < m_cnt) begin
                if (num_inst == t_ni[m_passed]) begin
                    if ((out_port & t_mask[m_passed]) ==
                        (t_ans[m_passed] & t_mask[m_passed]))
                        m_passed++;
                    else begin
                        model_fail(1, m_passed); bad = 1;
                    end
                end else if (num_inst > t_ni[m_passed]) begin
                    model_fail(2, m_passed); bad = 1;
                end
            end
            if (!bad) begin
                if (halt) begin
                    if (m_passed == m_cnt) m_st = M_PASS;
                    else model_fail(2, m_passed);
                end
`ifdef RISCV_CHECKER_TIMEOUT_EN
                else if (m_cyc == TO) model_fail(3, m_passed);
`endif
            end
        end else begin
            if (cfg_we && m_st == M_IDLE) begin
                t_ni[cfg_idx]   = cfg_ni;
                t_ans[cfg_idx]  = cfg_ans;
                t_mask[cfg_idx] = cfg_mask;
            end
            if (start) begin
                m_st = M_RUN; m_passed = 0; m_cyc = 0;
                m_code = 0; m_idx = 0; m_val = '0;
                m_cnt = (cfg_count > 32) ? 32 : int'(cfg_count);
            end
        end
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clk) begin
        if (armed) begin
            logic [79:0] act, exp;
            act = {busy, done, pass, fcode, fidx, fval, pcnt, cyc};
            exp = {m_st == M_RUN, m_st == M_PASS || m_st == M_FAIL,
                   m_st == M_PASS, 2'(m_code), 5'(m_idx), m_val,
                   6'(m_passed), 32'(m_cyc)};
            n_tests++;
            if (act !== exp) begin
                n_fail++;
                $display("FAIL model_cmp t=%0t got %h expected %h",
                         $time, act, exp);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] a,
                       input logic [31:0] e);
        n_tests++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s got %h expected %h", name, a, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic load(input int i, input logic [31:0] n,
                        input logic [31:0] a, input logic [31:0] m);
        cfg_we = 1'b1; cfg_idx = 5'(i); cfg_ni = n; cfg_ans = a; cfg_mask = m;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic do_start(input int c);
        cfg_count = 6'(c);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic step(input logic [31:0] n, input logic [31:0] o,
                        input logic h);
        num_inst = n; out_port = o; halt = h;
        tick();
        halt = 1'b0;
    endtask

    function automatic logic [31:0] t1_out(input int n, input int bad6);
        if (n == 4) return 32'heec;
        if (n == 6) return bad6 ? 32'h5 : 32'h0;
        if (n == 8) return 32'h1;
        return 32'hdead;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r_ni [8];
        logic [31:0] r_ans [8];
        logic [31:0] r_mask [8];
        do_reset();
        armed = 1;
        chk("reset_busy", 32'(busy), 0);
        chk("reset_cycle", cyc, 0);

        load(0, 4, 32'heec, '1);
        load(1, 6, 32'h0, '1);
        load(2, 8, 32'h1, '1);
        do_start(3);
        for (int n = 0; n <= 10; n++) step(n, t1_out(n, 0), n == 10);
        chk("t1_pass", 32'(pass), 1);
        chk("t1_pass_cnt", 32'(pcnt), 3);
        chk("t1_code", 32'(fcode), 0);
        chk("t1_cycle", cyc, 11);

        do_start(3);
        for (int n = 0; n <= 10; n++) step(n, t1_out(n, 1), n == 10);
        chk("t2_done", 32'(done), 1);
        chk("t2_code", 32'(fcode), 1);
        chk("t2_idx", 32'(fidx), 1);
        chk("t2_value", fval, 32'h5);

        do_start(3);
        step(4, 32'heec, 0);
        step(7, 32'h0, 0);
        chk("t3a_code", 32'(fcode), 2);
        chk("t3a_idx", 32'(fidx), 1);
        do_start(3);
        step(4, 32'heec, 0);
        step(5, 32'h0, 1);
        chk("t3b_code", 32'(fcode), 2);
        chk("t3b_idx", 32'(fidx), 1);

        do_start(0);
        step(0, 32'h0, 1);
        chk("cnt0_pass", 32'(pass), 1);
        chk("cnt0_pass_cnt", 32'(pcnt), 0);

        do_reset();
        load(0, 3, 32'h12ab, 32'h00ff);
        load(1, 5, 32'h7, '1);
        do_start(2);
        step(3, 32'hffab, 0);
        step(4, 32'h0, 0);
        step(5, 32'h7, 1);
        chk("t4_pass", 32'(pass), 1);
        chk("t4_pass_cnt", 32'(pcnt), 2);

`ifdef RISCV_CHECKER_TIMEOUT_EN
        do_start(2);
        for (int k = 0; k < TO; k++) step(0, 32'h0, 0);
        chk("t5_code", 32'(fcode), 3);
        chk("t5_cycle", cyc, TO);
`endif
        do_start(2);
        for (int k = 0; k < 8; k++) step(0, 32'h0, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_rst_busy", 32'(busy), 0);
        chk("t5_rst_cycle", cyc, 0);
        do_start(2);
        step(3, 32'hffab, 0);
        step(5, 32'h7, 1);
        chk("t5_retain_pass", 32'(pass), 1);

        do_start(2);
        cfg_we = 1'b1; cfg_idx = 5'd1; cfg_ni = 5; cfg_ans = 32'h99; cfg_mask = '1;
        step(3, 32'hffab, 0);
        cfg_we = 1'b0;
        step(5, 32'h7, 1);
        chk("t6_pass", 32'(pass), 1);

        for (int r = 0; r < 30; r++) begin
            int n;
            logic [31:0] base, ni;
            do_reset();
            n = $urandom_range(0, 6);
            base = 0;
            for (int j = 0; j < n; j++) begin
                base = base + $urandom_range(0, 3);
                r_ni[j]   = base;
                r_ans[j]  = $urandom;
                r_mask[j] = ($urandom_range(0, 1) == 1) ? '1 : $urandom;
                load(j, r_ni[j], r_ans[j], r_mask[j]);
            end
            do_start(n);
            ni = 0;
            for (int c = 0; c < 40; c++) begin
                logic [31:0] o;
                ni = ni + $urandom_range(0, 2);
                o = $urandom;
                for (int j = 0; j < n; j++)
                    if (r_ni[j] == ni && $urandom_range(0, 3) != 0)
                        o = (r_ans[j] & r_mask[j]) | (o & ~r_mask[j]);
                cfg_we = ($urandom_range(0, 9) == 0);
                cfg_idx = 5'($urandom_range(0, 7));
                cfg_ni = $urandom; cfg_ans = $urandom; cfg_mask = $urandom;
                start = ($urandom_range(0, 24) == 0);
                step(ni, o, c == 39 || $urandom_range(0, 19) == 0);
                start = 1'b0;
                cfg_we = 1'b0;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
